// File: rtl/result_packer_if.sv
// Handshake bundles around the result packer: the request side from logic_control
// and the write side into the 16-bit output FIFO.

interface result_rec_if;
   logic        rec_req;
   logic [1:0]  rec_type;
   logic [1:0]  adc_ch;
   logic [13:0] adc_data;
   logic [47:0] time_in;
   logic        rdy;

   modport master (output rec_req, rec_type, adc_ch, adc_data, time_in, input rdy);
   modport slave  (input rec_req, rec_type, adc_ch, adc_data, time_in, output rdy);
endinterface

interface result_fifo_if;
   logic [15:0] fifo_din;
   logic        fifo_wr;
   logic        fifo_full;

   modport master (output fifo_din, fifo_wr, input fifo_full);
   modport slave  (input fifo_din, fifo_wr, output fifo_full);
endinterface

// File: rtl/result_packer.sv
// Frames ADC results and timestamps into 16-bit records (header plus payload words)
// for the host output FIFO, honouring FIFO backpressure and counting bad requests.

module result_packer #(
   parameter logic [3:0] HDR_TAG = 4'hA
) (
   input  logic               clk,
   input  logic               rst_n,
   result_rec_if.slave        rec,
   result_fifo_if.master      fifo,
   output logic [7:0]         seq,
   output logic [7:0]         drop_cnt,
   output logic [7:0]         err_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_ADC,
      S_T2,
      S_T1,
      S_T0
   } state_t;

   state_t      state;
   state_t      next_state;
   logic [1:0]  hold_type;
   logic [1:0]  hold_ch;
   logic [13:0] hold_data;
   logic [47:0] hold_time;
   logic [15:0] word;
   logic        wr;
   logic        ready;
   logic        accept;

   assign ready   = (state == S_IDLE) & rst_n;
   assign wr      = (state != S_IDLE) & ~fifo.fifo_full & rst_n;
   assign accept  = rec.rec_req & ready;

   assign rec.rdy       = ready;
   assign fifo.fifo_wr  = wr;
   assign fifo.fifo_din = word;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         seq       <= 8'd0;
         drop_cnt  <= 8'd0;
         err_cnt   <= 8'd0;
         hold_type <= 2'd0;
         hold_ch   <= 2'd0;
         hold_data <= 14'd0;
         hold_time <= 48'd0;
      end else begin
         state <= next_state;
         if (accept) begin
            hold_type <= rec.rec_type;
            hold_ch   <= rec.adc_ch;
            hold_data <= rec.adc_data;
            hold_time <= rec.time_in;
         end
         if (accept && rec.rec_type == 2'd0 && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
         if (rec.rec_req && !ready && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
         // The header carries the pre-increment value, so bump only once it is really written.
         if (state == S_HDR && wr)
            seq <= seq + 8'd1;
      end
   end

   always_comb begin
      next_state = state;
      word       = 16'h0000;
      case (state)
         S_IDLE: begin
            if (accept && rec.rec_type != 2'd0)
               next_state = S_HDR;
         end
         S_HDR: begin
            word = {HDR_TAG, 2'b00, hold_type, seq};
            if (wr)
               next_state = (hold_type == 2'd2) ? S_T2 : S_ADC;
         end
         S_ADC: begin
            word = {hold_ch, hold_data};
            if (wr)
               next_state = (hold_type == 2'd3) ? S_T2 : S_IDLE;
         end
         S_T2: begin
            word = hold_time[47:32];
            if (wr)
               next_state = S_T1;
         end
         S_T1: begin
            word = hold_time[31:16];
            if (wr)
               next_state = S_T0;
         end
         S_T0: begin
            word = hold_time[15:0];
            if (wr)
               next_state = S_IDLE;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_result_packer.sv
// Directed bench for result_packer: record framing, stalls, drops, saturation,
// sequence wrap and mid-record reset, with hand-computed expected words.

module tb_result_packer;

   logic       clk;
   logic       rst_n;
   logic [7:0] seq;
   logic [7:0] drop_cnt;
   logic [7:0] err_cnt;

   result_rec_if  rec ();
   result_fifo_if fifo ();

   result_packer #(.HDR_TAG(4'hA)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rec      (rec.slave),
      .fifo     (fifo.master),
      .seq      (seq),
      .drop_cnt (drop_cnt),
      .err_cnt  (err_cnt)
   );

   int checkCount = 0;
   int errorCount = 0;
   logic [15:0] wq[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs only move 1ns after a rising edge, so the falling edge sees what the next edge will.
   always @(negedge clk) begin
      if (fifo.fifo_wr)
         wq.push_back(fifo.fifo_din);
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] rtype, input logic [1:0] ch,
                                input logic [13:0] data, input logic [47:0] tim);
      int budget;
      rec.rec_req  = 1'b1;
      rec.rec_type = rtype;
      rec.adc_ch   = ch;
      rec.adc_data = data;
      rec.time_in  = tim;
      tick();
      rec.rec_req = 1'b0;
      budget = 20;
      while (!rec.rdy && budget > 0) begin
         tick();
         budget--;
      end
      if (budget == 0)
         checkOutput("rdy_timeout", 64'(rec.rdy), 64'd1);
   endtask

   initial begin
      int stallBad;
      int idleBad;

      rst_n          = 1'b0;
      rec.rec_req    = 1'b0;
      rec.rec_type   = 2'd0;
      rec.adc_ch     = 2'd0;
      rec.adc_data   = 14'd0;
      rec.time_in    = 48'd0;
      fifo.fifo_full = 1'b0;

      // Reset state
      tick();
      tick();
      checkOutput("rst_rdy", 64'(rec.rdy), 64'd0);
      checkOutput("rst_wr", 64'(fifo.fifo_wr), 64'd0);
      rst_n = 1'b1;
      #1;
      checkOutput("idle_rdy", 64'(rec.rdy), 64'd1);
      checkOutput("idle_din", 64'(fifo.fifo_din), 64'h0000);
      checkOutput("rst_seq", 64'(seq), 64'd0);
      checkOutput("rst_drop", 64'(drop_cnt), 64'd0);
      checkOutput("rst_err", 64'(err_cnt), 64'd0);

      // Type 1, stepped cycle by cycle
      rec.rec_req  = 1'b1;
      rec.rec_type = 2'd1;
      rec.adc_ch   = 2'd2;
      rec.adc_data = 14'h1ABC;
      tick();
      rec.rec_req  = 1'b0;
      rec.adc_data = 14'h0000;
      checkOutput("t1_hdr_wr", 64'(fifo.fifo_wr), 64'd1);
      checkOutput("t1_hdr", 64'(fifo.fifo_din), 64'hA100);
      checkOutput("t1_busy", 64'(rec.rdy), 64'd0);
      tick();
      checkOutput("t1_adc", 64'(fifo.fifo_din), 64'h9ABC);
      checkOutput("t1_adc_wr", 64'(fifo.fifo_wr), 64'd1);
      tick();
      checkOutput("t1_rdy", 64'(rec.rdy), 64'd1);
      checkOutput("t1_seq", 64'(seq), 64'd1);

      // Advance seq to 7, then a type-3 record
      for (int i = 0; i < 6; i++)
         applyStimulus(2'd1, 2'd0, 14'd0, 48'd0);
      checkOutput("seq7", 64'(seq), 64'd7);
      wq.delete();
      applyStimulus(2'd3, 2'd0, 14'h0005, 48'h0123_4567_89AB);
      checkOutput("t3_count", 64'(wq.size()), 64'd5);
      if (wq.size() == 5) begin
         checkOutput("t3_w0", 64'(wq[0]), 64'hA307);
         checkOutput("t3_w1", 64'(wq[1]), 64'h0005);
         checkOutput("t3_w2", 64'(wq[2]), 64'h0123);
         checkOutput("t3_w3", 64'(wq[3]), 64'h4567);
         checkOutput("t3_w4", 64'(wq[4]), 64'h89AB);
      end
      checkOutput("t3_seq", 64'(seq), 64'd8);

      // Type 2 with a 10-cycle stall after the header
      wq.delete();
      rec.rec_req  = 1'b1;
      rec.rec_type = 2'd2;
      rec.time_in  = 48'hDEAD_BEEF_CAFE;
      tick();
      rec.rec_req = 1'b0;
      rec.time_in = 48'd0;
      checkOutput("st_hdr", 64'(fifo.fifo_din), 64'hA208);
      tick();
      fifo.fifo_full = 1'b1;
      stallBad = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (fifo.fifo_wr !== 1'b0 || fifo.fifo_din !== 16'hDEAD)
            stallBad++;
         tick();
      end
      checkOutput("st_hold", 64'(stallBad), 64'd0);
      fifo.fifo_full = 1'b0;
      #1;
      checkOutput("st_release_wr", 64'(fifo.fifo_wr), 64'd1);
      checkOutput("st_release_din", 64'(fifo.fifo_din), 64'hDEAD);
      tick();
      checkOutput("st_t1", 64'(fifo.fifo_din), 64'hBEEF);
      tick();
      checkOutput("st_t0", 64'(fifo.fifo_din), 64'hCAFE);
      tick();
      checkOutput("st_rdy", 64'(rec.rdy), 64'd1);
      checkOutput("st_count", 64'(wq.size()), 64'd4);
      checkOutput("st_seq", 64'(seq), 64'd9);

      // Drops during a type-2 record, one of them on the last write
      wq.delete();
      rec.rec_req  = 1'b1;
      rec.rec_type = 2'd2;
      rec.time_in  = 48'h1111_2222_3333;
      tick();
      rec.rec_type = 2'd3;
      rec.time_in  = 48'hFFFF_FFFF_FFFF;
      tick();
      tick();
      rec.rec_req = 1'b0;
      tick();
      rec.rec_req = 1'b1;
      tick();
      rec.rec_req = 1'b0;
      checkOutput("dr_drop", 64'(drop_cnt), 64'd3);
      checkOutput("dr_rdy", 64'(rec.rdy), 64'd1);
      checkOutput("dr_count", 64'(wq.size()), 64'd4);
      if (wq.size() == 4) begin
         checkOutput("dr_w0", 64'(wq[0]), 64'hA209);
         checkOutput("dr_w1", 64'(wq[1]), 64'h1111);
         checkOutput("dr_w3", 64'(wq[3]), 64'h3333);
      end

      // 300 type-0 requests saturate err_cnt
      rec.rec_type = 2'd0;
      rec.rec_req  = 1'b1;
      idleBad = 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (rec.rdy !== 1'b1)
            idleBad++;
      end
      rec.rec_req = 1'b0;
      checkOutput("e0_rdy", 64'(idleBad), 64'd0);
      checkOutput("e0_err", 64'(err_cnt), 64'd255);
      checkOutput("e0_drop", 64'(drop_cnt), 64'd3);
      checkOutput("e0_seq", 64'(seq), 64'd10);
      checkOutput("e0_nowr", 64'(wq.size()), 64'd4);

      // Sequence wrap over 256 records
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      checkOutput("wr_clr_err", 64'(err_cnt), 64'd0);
      checkOutput("wr_clr_drop", 64'(drop_cnt), 64'd0);
      wq.delete();
      for (int i = 0; i < 256; i++)
         applyStimulus(2'd1, 2'd1, 14'(i), 48'd0);
      checkOutput("wrap_count", 64'(wq.size()), 64'd512);
      if (wq.size() == 512) begin
         checkOutput("wrap_first", 64'(wq[0]), 64'hA100);
         checkOutput("wrap_last_hdr", 64'(wq[510]), 64'hA1FF);
         checkOutput("wrap_last_adc", 64'(wq[511]), 64'h40FF);
      end
      checkOutput("wrap_seq", 64'(seq), 64'd0);

      // Reset in the middle of a type-3 record
      wq.delete();
      rec.rec_req  = 1'b1;
      rec.rec_type = 2'd3;
      rec.adc_ch   = 2'd3;
      rec.adc_data = 14'h0042;
      rec.time_in  = 48'hAAAA_BBBB_CCCC;
      tick();
      rec.rec_type = 2'd1;
      tick();
      rec.rec_req = 1'b0;
      tick();
      checkOutput("mr_drop", 64'(drop_cnt), 64'd1);
      checkOutput("mr_seq", 64'(seq), 64'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("mr_wr_low", 64'(fifo.fifo_wr), 64'd0);
      checkOutput("mr_rdy_low", 64'(rec.rdy), 64'd0);
      tick();
      rst_n = 1'b1;
      #1;
      checkOutput("mr_rdy", 64'(rec.rdy), 64'd1);
      checkOutput("mr_seq0", 64'(seq), 64'd0);
      checkOutput("mr_drop0", 64'(drop_cnt), 64'd0);
      checkOutput("mr_din", 64'(fifo.fifo_din), 64'h0000);
      for (int i = 0; i < 5; i++)
         tick();
      checkOutput("mr_count", 64'(wq.size()), 64'd2);
      if (wq.size() == 2)
         checkOutput("mr_adc", 64'(wq[1]), 64'hC042);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
